// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: MEM-stage store/load ports, DM write port and status.
interface store_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // Store side
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic          st_byte;
  logic          st_half;
  logic [31:0]   st_pc;
  logic          st_ready;

  // Load check
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [31:0]   ld_hit_data;
  logic          ld_stall;

  // DM write port
  logic          dm_ready;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_data;
  logic          dm_byte;
  logic          dm_half;
  logic [31:0]   dm_pc;

  // Status
  logic [CW-1:0] count;
  logic          empty;

  modport slave (
    input  st_valid, st_addr, st_data, st_byte, st_half, st_pc,
    input  ld_valid, ld_addr, dm_ready,
    output st_ready, ld_hit, ld_hit_data, ld_stall,
    output dm_we, dm_addr, dm_data, dm_byte, dm_half, dm_pc,
    output count, empty
  );

  modport master (
    output st_valid, st_addr, st_data, st_byte, st_half, st_pc,
    output ld_valid, ld_addr, dm_ready,
    input  st_ready, ld_hit, ld_hit_data, ld_stall,
    input  dm_we, dm_addr, dm_data, dm_byte, dm_half, dm_pc,
    input  count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between MEM and data memory: in-order drain, word-granular
// load forwarding from the youngest matching entry, stall on partial-width hits.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [DEPTH-1:0] byte_q, half_q;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic st_ready, empty, push, pop;
  logic found, hit_word;
  logic [31:0] hit_data;
  logic [PW-1:0] idx;

  assign st_ready = (count_q != CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = bus.st_valid & st_ready;
  assign pop      = ~empty & bus.dm_ready;

  // Next-state for pointers, count and valid bits
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards all pending stores, even mid-drain
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Entry payload; no reset needed since valid_q gates every use
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.st_addr;
      data_q[wr_ptr_q] <= bus.st_data;
      pc_q[wr_ptr_q]   <= bus.st_pc;
      byte_q[wr_ptr_q] <= bus.st_byte;
      half_q[wr_ptr_q] <= bus.st_half;
    end
  end

  // Youngest-first search backwards from wr_ptr-1; a popping head still matches
  always_comb begin
    found    = 1'b0;
    hit_word = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 1; k <= int'(DEPTH); k++) begin
      idx = wr_ptr_q - PW'(k);
      if (!found && valid_q[idx] && (addr_q[idx][AW-1:2] == bus.ld_addr[AW-1:2])) begin
        found    = 1'b1;
        hit_word = ~byte_q[idx] & ~half_q[idx];
        hit_data = data_q[idx];
      end
    end
  end

  // Outputs: head entry drives the DM port; load result gated by ld_valid
  always_comb begin
    bus.st_ready    = st_ready;
    bus.empty       = empty;
    bus.count       = count_q;
    bus.dm_we       = pop;
    bus.dm_addr     = addr_q[rd_ptr_q];
    bus.dm_data     = data_q[rd_ptr_q];
    bus.dm_pc       = pc_q[rd_ptr_q];
    bus.dm_byte     = byte_q[rd_ptr_q];
    bus.dm_half     = half_q[rd_ptr_q];
    bus.ld_hit_data = hit_data;
    // A concurrent store means the load cannot be serviced this cycle
    bus.ld_hit      = bus.ld_valid & ~bus.st_valid & found & hit_word;
    bus.ld_stall    = bus.ld_valid & (bus.st_valid | (found & ~hit_word));
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, drain latency, full/ignore, forwarding,
// partial-width stall, pointer wrap and simultaneous push/pop.
module tb_store_buffer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  store_buffer_if #(.DEPTH(4), .AW(32)) sbus ();

  store_buffer #(.DEPTH(4), .AW(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic b, input logic h);
    sbus.st_valid = 1'b1;
    sbus.st_addr  = a;
    sbus.st_data  = d;
    sbus.st_byte  = b;
    sbus.st_half  = h;
    sbus.st_pc    = a + 32'h1000;
    tick();
    sbus.st_valid = 1'b0;
    #1;
  endtask

  initial begin
    sbus.st_valid = 0; sbus.st_addr = 0; sbus.st_data = 0; sbus.st_byte = 0;
    sbus.st_half = 0; sbus.st_pc = 0; sbus.ld_valid = 0; sbus.ld_addr = 0;
    sbus.dm_ready = 0;
    tick(); tick();
    reset = 1'b1;

    // 1: reset discards held entries
    for (int i = 0; i < 3; i++) push(32'h100 + 32'(i * 4), 32'(i), 1'b0, 1'b0);
    check("pre_reset_count", 32'(sbus.count), 32'd3);
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    sbus.dm_ready = 1'b1;
    sbus.ld_valid = 1'b1;
    sbus.ld_addr  = 32'h100;
    #1;
    check("rst_count", 32'(sbus.count), 32'd0);
    check("rst_empty", 32'(sbus.empty), 32'd1);
    check("rst_st_ready", 32'(sbus.st_ready), 32'd1);
    check("rst_dm_we", 32'(sbus.dm_we), 32'd0);
    check("rst_ld_hit", 32'(sbus.ld_hit), 32'd0);
    check("rst_ld_stall", 32'(sbus.ld_stall), 32'd0);
    sbus.ld_valid = 1'b0;

    // 2: one-cycle drain latency
    push(32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    check("t2_dm_we", 32'(sbus.dm_we), 32'd1);
    check("t2_dm_addr", sbus.dm_addr, 32'h10);
    check("t2_dm_data", sbus.dm_data, 32'hDEADBEEF);
    check("t2_dm_pc", sbus.dm_pc, 32'h1010);
    tick();
    check("t2_empty", 32'(sbus.empty), 32'd1);

    // 3: fill, ignore fifth store, drain in order
    sbus.dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'(i * 4), 32'hA0 + 32'(i), 1'b0, 1'b0);
    check("t3_count_full", 32'(sbus.count), 32'd4);
    check("t3_st_ready", 32'(sbus.st_ready), 32'd0);
    push(32'h40, 32'hBAD, 1'b0, 1'b0);
    check("t3_count_ignored", 32'(sbus.count), 32'd4);
    sbus.dm_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t3_dm_we", 32'(sbus.dm_we), 32'd1);
      check("t3_dm_addr", sbus.dm_addr, 32'(i * 4));
      check("t3_dm_data", sbus.dm_data, 32'hA0 + 32'(i));
      tick();
    end
    check("t3_empty", 32'(sbus.empty), 32'd1);
    check("t3_dm_we_idle", 32'(sbus.dm_we), 32'd0);

    // 4: word forwarding, ld_valid gating, store+load collision
    sbus.dm_ready = 1'b0;
    push(32'h20, 32'h12345678, 1'b0, 1'b0);
    sbus.ld_valid = 1'b1;
    sbus.ld_addr  = 32'h22;
    #1;
    check("t4_ld_hit", 32'(sbus.ld_hit), 32'd1);
    check("t4_ld_data", sbus.ld_hit_data, 32'h12345678);
    check("t4_ld_stall", 32'(sbus.ld_stall), 32'd0);
    sbus.ld_valid = 1'b0;
    #1;
    check("t4_novalid_hit", 32'(sbus.ld_hit), 32'd0);
    sbus.ld_valid = 1'b1;
    sbus.st_valid = 1'b1;
    sbus.st_addr  = 32'h30;
    sbus.st_data  = 32'h77;
    sbus.st_byte  = 1'b0;
    sbus.st_half  = 1'b0;
    #1;
    check("t4_coll_stall", 32'(sbus.ld_stall), 32'd1);
    check("t4_coll_hit", 32'(sbus.ld_hit), 32'd0);
    tick();
    sbus.st_valid = 1'b0;
    sbus.ld_valid = 1'b0;
    check("t4_coll_count", 32'(sbus.count), 32'd2);
    sbus.dm_ready = 1'b1;
    tick(); tick();
    check("t4_drained", 32'(sbus.empty), 32'd1);

    // 5: youngest word wins; byte-only match stalls until drained
    sbus.dm_ready = 1'b0;
    push(32'h24, 32'h11, 1'b1, 1'b0);
    push(32'h24, 32'hAABBCCDD, 1'b0, 1'b0);
    sbus.ld_valid = 1'b1;
    sbus.ld_addr  = 32'h25;
    #1;
    check("t5_hit", 32'(sbus.ld_hit), 32'd1);
    check("t5_data", sbus.ld_hit_data, 32'hAABBCCDD);
    check("t5_nostall", 32'(sbus.ld_stall), 32'd0);
    sbus.ld_valid = 1'b0;
    sbus.dm_ready = 1'b1;
    tick(); tick();
    sbus.dm_ready = 1'b0;
    push(32'h28, 32'h55, 1'b1, 1'b0);
    sbus.ld_valid = 1'b1;
    sbus.ld_addr  = 32'h28;
    #1;
    check("t5_b_stall", 32'(sbus.ld_stall), 32'd1);
    check("t5_b_hit", 32'(sbus.ld_hit), 32'd0);
    tick();
    check("t5_b_stall_hold", 32'(sbus.ld_stall), 32'd1);
    sbus.dm_ready = 1'b1;
    #1;
    check("t5_b_stall_pop", 32'(sbus.ld_stall), 32'd1);
    check("t5_b_dm_byte", 32'(sbus.dm_byte), 32'd1);
    tick();
    check("t5_b_stall_clr", 32'(sbus.ld_stall), 32'd0);
    check("t5_b_hit_clr", 32'(sbus.ld_hit), 32'd0);
    sbus.ld_valid = 1'b0;
    sbus.dm_ready = 1'b0;
    // Older word, younger half to the same word -> stall
    push(32'h2C, 32'h99, 1'b0, 1'b0);
    push(32'h2E, 32'h88, 1'b0, 1'b1);
    sbus.ld_valid = 1'b1;
    sbus.ld_addr  = 32'h2C;
    #1;
    check("t5_h_stall", 32'(sbus.ld_stall), 32'd1);
    check("t5_h_hit", 32'(sbus.ld_hit), 32'd0);
    sbus.ld_valid = 1'b0;
    sbus.dm_ready = 1'b1;
    #1;
    check("t5_h_dm_half", 32'(sbus.dm_half), 32'd0);
    tick();
    check("t5_h_dm_half2", 32'(sbus.dm_half), 32'd1);
    tick();
    check("t5_h_empty", 32'(sbus.empty), 32'd1);

    // 6: wrap across index 3->0, then push+pop at count=2
    sbus.dm_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h200 + 32'(i * 4), 32'(i), 1'b0, 1'b0);
    sbus.dm_ready = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("t6_drain_a", sbus.dm_addr, 32'h200 + 32'(i * 4));
      tick();
    end
    sbus.dm_ready = 1'b0;
    for (int i = 3; i < 6; i++) push(32'h200 + 32'(i * 4), 32'(i), 1'b0, 1'b0);
    check("t6_count4", 32'(sbus.count), 32'd4);
    sbus.dm_ready = 1'b1;
    #1;
    for (int i = 2; i < 4; i++) begin
      check("t6_drain_b", sbus.dm_addr, 32'h200 + 32'(i * 4));
      tick();
    end
    check("t6_count2", 32'(sbus.count), 32'd2);
    sbus.st_valid = 1'b1;
    sbus.st_addr  = 32'h218;
    sbus.st_data  = 32'd6;
    sbus.st_byte  = 1'b0;
    sbus.st_half  = 1'b0;
    #1;
    check("t6_pp_addr", sbus.dm_addr, 32'h210);
    tick();
    sbus.st_valid = 1'b0;
    check("t6_pp_count", 32'(sbus.count), 32'd2);
    for (int i = 5; i < 7; i++) begin
      check("t6_drain_c", sbus.dm_addr, 32'h200 + 32'(i * 4));
      check("t6_drain_cd", sbus.dm_data, 32'(i));
      tick();
    end
    check("t6_empty", 32'(sbus.empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
